// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer between fetch and decode: one FIFO per warp, round-robin issue across warps.
// Latency: an entry written at edge N is visible on out_* after edge N (no same-cycle bypass).
// Backpressure: in_ready drops while the target warp FIFO is full; a stalled grant is held stable until it fires.
module vx_warp_ibuffer #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 31,
    parameter int UUID_WIDTH  = 44,
    parameter int IBUF_SIZE   = 4,
    localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [NW_WIDTH-1:0]    in_wid,
    input  logic [NUM_THREADS-1:0] in_tmask,
    input  logic [PC_BITS-1:0]     in_PC,
    input  logic [31:0]            in_instr,
    input  logic [UUID_WIDTH-1:0]  in_uuid,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [NW_WIDTH-1:0]    out_wid,
    output logic [NUM_THREADS-1:0] out_tmask,
    output logic [PC_BITS-1:0]     out_PC,
    output logic [31:0]            out_instr,
    output logic [UUID_WIDTH-1:0]  out_uuid,
    input  logic                   out_ready,
    output logic [NUM_WARPS-1:0]   ibuf_pop
);
    localparam int AW = (IBUF_SIZE > 1) ? $clog2(IBUF_SIZE) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
        logic [31:0]            instr;
        logic [UUID_WIDTH-1:0]  uuid;
    } entry_t;

    typedef enum logic {IDLE, LOCKED} lock_state_t;

    entry_t               mem    [NUM_WARPS][IBUF_SIZE];
    logic [AW-1:0]        rd_ptr [NUM_WARPS];
    logic [AW-1:0]        wr_ptr [NUM_WARPS];
    logic [CW-1:0]        count  [NUM_WARPS];
    logic [NW_WIDTH-1:0]  rr_idx [NUM_WARPS];
    logic [NUM_WARPS-1:0] nonempty;
    logic [NUM_WARPS-1:0] push_vec;
    logic [NW_WIDTH-1:0]  rr_ptr;
    logic [NW_WIDTH-1:0]  rr_grant;
    logic [NW_WIDTH-1:0]  grant;
    logic [NW_WIDTH-1:0]  grant_nxt;
    logic [NW_WIDTH-1:0]  lock_wid;
    lock_state_t          lock_state;
    logic                 in_fire;
    logic                 out_fire;
    entry_t               in_dat;
    entry_t               head_dat;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            nonempty[w] = (count[w] != '0);
            rr_idx[w]   = NW_WIDTH'((int'(rr_ptr) + w) % NUM_WARPS);
        end
    end

    // Scan from the far end so the closest nonempty warp at or after rr_ptr wins.
    always_comb begin
        rr_grant = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (nonempty[rr_idx[i]])
                rr_grant = rr_idx[i];
        end
    end

    assign grant     = (lock_state == LOCKED) ? lock_wid : rr_grant;
    assign grant_nxt = (int'(grant) == NUM_WARPS - 1) ? '0 : grant + NW_WIDTH'(1);

    assign in_ready  = (count[in_wid] != CW'(IBUF_SIZE));
    assign out_valid = |nonempty;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign in_dat    = {in_tmask, in_PC, in_instr, in_uuid};
    assign head_dat  = mem[grant][rd_ptr[grant]];
    assign out_wid   = grant;
    assign out_tmask = head_dat.tmask;
    assign out_PC    = head_dat.pc;
    assign out_instr = head_dat.instr;
    assign out_uuid  = head_dat.uuid;

    assign ibuf_pop  = out_fire ? (NUM_WARPS'(1) << grant) : '0;
    assign push_vec  = in_fire ? (NUM_WARPS'(1) << in_wid) : '0;

    always_ff @(posedge clk) begin
        if (in_fire)
            mem[in_wid][wr_ptr[in_wid]] <= in_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr[w] <= '0;
                wr_ptr[w] <= '0;
                count[w]  <= '0;
            end
            rr_ptr     <= '0;
            lock_wid   <= '0;
            lock_state <= IDLE;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (push_vec[w])
                    wr_ptr[w] <= wr_ptr[w] + AW'(1);
                if (ibuf_pop[w])
                    rd_ptr[w] <= rd_ptr[w] + AW'(1);
                if (push_vec[w] && !ibuf_pop[w])
                    count[w] <= count[w] + CW'(1);
                else if (!push_vec[w] && ibuf_pop[w])
                    count[w] <= count[w] - CW'(1);
            end
            if (out_fire)
                rr_ptr <= grant_nxt;
            case (lock_state)
                IDLE: begin
                    if (out_valid && !out_ready) begin
                        lock_state <= LOCKED;
                        lock_wid   <= grant;
                    end
                end
                LOCKED: begin
                    if (out_fire)
                        lock_state <= IDLE;
                end
                default: lock_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Self-checking bench for vx_warp_ibuffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_vx_warp_ibuffer;
    localparam int NW    = 4;
    localparam int NT    = 4;
    localparam int PCB   = 31;
    localparam int UW    = 44;
    localparam int DEPTH = 4;
    localparam int EW    = NT + PCB + 32 + UW;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [1:0]     in_wid;
    logic [NT-1:0]  in_tmask;
    logic [PCB-1:0] in_PC;
    logic [31:0]    in_instr;
    logic [UW-1:0]  in_uuid;
    logic           in_ready;
    logic           out_valid;
    logic [1:0]     out_wid;
    logic [NT-1:0]  out_tmask;
    logic [PCB-1:0] out_PC;
    logic [31:0]    out_instr;
    logic [UW-1:0]  out_uuid;
    logic           out_ready;
    logic [NW-1:0]  ibuf_pop;

    vx_warp_ibuffer #(
        .NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PCB), .UUID_WIDTH(UW), .IBUF_SIZE(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC),
        .in_instr(in_instr), .in_uuid(in_uuid), .in_ready(in_ready),
        .out_valid(out_valid), .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC),
        .out_instr(out_instr), .out_uuid(out_uuid), .out_ready(out_ready),
        .ibuf_pop(ibuf_pop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per warp, a round-robin start pointer and a held grant while stalled.
    logic [EW-1:0] q [NW][$];
    int m_rr = 0;
    bit m_locked = 1'b0;
    int m_lock_wid = 0;

    function automatic bit m_valid();
        for (int w = 0; w < NW; w++)
            if (q[w].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_grant();
        if (m_locked) return m_lock_wid;
        for (int i = 0; i < NW; i++)
            if (q[(m_rr + i) % NW].size() != 0) return (m_rr + i) % NW;
        return 0;
    endfunction

    function automatic logic [EW-1:0] m_head();
        int g;
        g = m_grant();
        if (q[g].size() == 0) return '0;
        return q[g][0];
    endfunction

    function automatic logic [EW-1:0] dut_dat();
        return {out_tmask, out_PC, out_instr, out_uuid};
    endfunction

    // Advance the model by one clock using the currently driven inputs, then cross the edge.
    task automatic tick();
        bit inf;
        bit outf;
        int g;
        g    = m_grant();
        inf  = in_valid && (q[in_wid].size() < DEPTH);
        outf = m_valid() && out_ready;
        if (reset) begin
            for (int w = 0; w < NW; w++) q[w].delete();
            m_rr     = 0;
            m_locked = 1'b0;
        end else begin
            if (outf) begin
                void'(q[g].pop_front());
                m_rr     = (g + 1) % NW;
                m_locked = 1'b0;
            end else if (m_valid() && !m_locked) begin
                m_locked   = 1'b1;
                m_lock_wid = g;
            end
            if (inf) q[in_wid].push_back({in_tmask, in_PC, in_instr, in_uuid});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int wid, input int pc, input logic [31:0] instr, input bit ordy);
        in_valid  = v;
        in_wid    = 2'(wid);
        in_PC     = PCB'(pc);
        in_instr  = instr;
        in_tmask  = NT'($urandom);
        in_uuid   = UW'({$urandom, $urandom});
        out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_cmp++; if (ibuf_pop !== 4'b0000) begin n_err++; $display("FAIL reset_ibuf_pop: got %b exp 0000", ibuf_pop); end
        for (int w = 0; w < NW; w++) begin
            in_wid = 2'(w);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: wid %0d got %b exp 1", w, in_ready); end
        end
        tick();
    endtask

    task automatic test_single_push();
        drive(1, 2, 'h40, 32'h0000_0013, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_bypass: got out_valid %b exp 0", out_valid); end
        tick();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b exp 1", out_valid); end
        n_cmp++; if (out_wid !== 2'd2) begin n_err++; $display("FAIL single_wid: got %0d exp 2", out_wid); end
        n_cmp++; if (out_instr !== 32'h13) begin n_err++; $display("FAIL single_instr: got %h exp 00000013", out_instr); end
        n_cmp++; if (out_PC !== PCB'('h40)) begin n_err++; $display("FAIL single_pc: got %h exp 40", out_PC); end
        n_cmp++; if (ibuf_pop !== 4'b0100) begin n_err++; $display("FAIL single_pop: got %b exp 0100", ibuf_pop); end
        tick();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b exp 0", out_valid); end
        tick();
    endtask

    task automatic test_fill();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 1, 'h10 + 2 * k, $urandom, 0);
            tick();
        end
        drive(0, 1, 0, 0, 0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_w1: got %b exp 0", in_ready); end
        in_wid = 2'd0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_w0: got %b exp 1", in_ready); end
        drive(1, 1, 'h18, $urandom, 0);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_fifth: got in_ready %b exp 0", in_ready); end
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 0, 0, 0, 1);
            n_cmp++; if (out_wid !== 2'd1) begin n_err++; $display("FAIL fill_wid: got %0d exp 1", out_wid); end
            n_cmp++; if (out_PC !== PCB'('h10 + 2 * k)) begin n_err++; $display("FAIL fill_order: got %h exp %h", out_PC, 'h10 + 2 * k); end
            n_cmp++; if (ibuf_pop !== 4'b0010) begin n_err++; $display("FAIL fill_pop: got %b exp 0010", ibuf_pop); end
            tick();
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_fifth_dropped: got out_valid %b exp 0", out_valid); end
        tick();
    endtask

    task automatic test_rr();
        do_reset();
        for (int w = 0; w < NW; w++) begin
            drive(1, w, 'h100 + 2 * w, $urandom, 0);
            tick();
        end
        for (int k = 0; k < NW; k++) begin
            drive(0, 0, 0, 0, 1);
            n_cmp++; if (out_wid !== 2'(k)) begin n_err++; $display("FAIL rr_wid: got %0d exp %0d", out_wid, k); end
            n_cmp++; if (ibuf_pop !== 4'(1 << k)) begin n_err++; $display("FAIL rr_pop: got %b exp %b", ibuf_pop, 4'(1 << k)); end
            n_cmp++; if (dut_dat() !== m_head()) begin n_err++; $display("FAIL rr_data: got %h exp %h", dut_dat(), m_head()); end
            tick();
        end
        drive(1, 0, 'h200, $urandom, 1);
        tick();
        drive(1, 3, 'h206, $urandom, 1);
        n_cmp++; if (out_wid !== 2'd0) begin n_err++; $display("FAIL rr_refill_first: got %0d exp 0", out_wid); end
        n_cmp++; if (out_PC !== PCB'('h200)) begin n_err++; $display("FAIL rr_refill_pc0: got %h exp 200", out_PC); end
        tick();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_wid !== 2'd3) begin n_err++; $display("FAIL rr_refill_second: got %0d exp 3", out_wid); end
        n_cmp++; if (out_PC !== PCB'('h206)) begin n_err++; $display("FAIL rr_refill_pc3: got %h exp 206", out_PC); end
        tick();
    endtask

    task automatic test_stall();
        logic [EW-1:0] held;
        do_reset();
        drive(1, 3, 'h300, $urandom, 0);
        tick();
        held = q[3][0];
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 0, 'h80, $urandom, 0);
            n_cmp++; if (out_wid !== 2'd3) begin n_err++; $display("FAIL stall_wid: cycle %0d got %0d exp 3", c, out_wid); end
            n_cmp++; if (dut_dat() !== held) begin n_err++; $display("FAIL stall_data: cycle %0d got %h exp %h", c, dut_dat(), held); end
            tick();
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (ibuf_pop !== 4'b1000) begin n_err++; $display("FAIL stall_fire: got %b exp 1000", ibuf_pop); end
        tick();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_wid !== 2'd0) begin n_err++; $display("FAIL stall_next: got %0d exp 0", out_wid); end
        n_cmp++; if (out_PC !== PCB'('h80)) begin n_err++; $display("FAIL stall_next_pc: got %h exp 80", out_PC); end
        tick();
    endtask

    task automatic test_full_pop();
        int exp_pc [4] = '{'h22, 'h24, 'h26, 'h2a};
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 2, 'h20 + 2 * k, $urandom, 0);
            tick();
        end
        drive(1, 2, 'h28, $urandom, 1);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_ready: got %b exp 0", in_ready); end
        n_cmp++; if (ibuf_pop !== 4'b0100) begin n_err++; $display("FAIL full_pop_pulse: got %b exp 0100", ibuf_pop); end
        tick();
        drive(1, 2, 'h2a, $urandom, 0);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_retry: got %b exp 1", in_ready); end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1);
            n_cmp++; if (out_PC !== PCB'(exp_pc[k])) begin n_err++; $display("FAIL full_pop_order: got %h exp %h", out_PC, exp_pc[k]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 'h400, $urandom, 0); tick();
        drive(1, 1, 'h402, $urandom, 0); tick();
        drive(1, 3, 'h404, $urandom, 0); tick();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b exp 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b exp 1", in_ready); end
        n_cmp++; if (ibuf_pop !== 4'b0000) begin n_err++; $display("FAIL midreset_pop: got %b exp 0000", ibuf_pop); end
        tick();
        drive(1, 1, 'h500, 32'hdead_beef, 1);
        n_cmp++; if (ibuf_pop !== 4'b0000) begin n_err++; $display("FAIL midreset_pop2: got %b exp 0000", ibuf_pop); end
        tick();
        drive(0, 0, 0, 0, 1);
        n_cmp++; if (out_wid !== 2'd1) begin n_err++; $display("FAIL midreset_wid: got %0d exp 1", out_wid); end
        n_cmp++; if (out_PC !== PCB'('h500)) begin n_err++; $display("FAIL midreset_pc: got %h exp 500", out_PC); end
        n_cmp++; if (ibuf_pop !== 4'b0010) begin n_err++; $display("FAIL midreset_fire: got %b exp 0010", ibuf_pop); end
        tick();
    endtask

    task automatic test_random();
        bit ordy;
        int g;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            ordy = ((cyc / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, NW - 1), $urandom, $urandom, ordy);
            g = m_grant();
            n_cmp++; if (in_ready !== (q[in_wid].size() < DEPTH)) begin n_err++; $display("FAIL rand_in_ready: cyc %0d got %b", cyc, in_ready); end
            n_cmp++; if (out_valid !== m_valid()) begin n_err++; $display("FAIL rand_out_valid: cyc %0d got %b exp %b", cyc, out_valid, m_valid()); end
            n_cmp++; if (ibuf_pop !== ((m_valid() && ordy) ? 4'(1 << g) : 4'b0)) begin n_err++; $display("FAIL rand_pop: cyc %0d got %b", cyc, ibuf_pop); end
            if (m_valid()) begin
                n_cmp++; if (out_wid !== 2'(g)) begin n_err++; $display("FAIL rand_wid: cyc %0d got %0d exp %0d", cyc, out_wid, g); end
                n_cmp++; if (dut_dat() !== m_head()) begin n_err++; $display("FAIL rand_data: cyc %0d got %h exp %h", cyc, dut_dat(), m_head()); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill();
        test_rr();
        test_stall();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
